adc_mux_sequencer: RTL and testbench
====================================

# adc_mux_sequencer

Sequencer that time-shares a single 8-bit ADC among four analog channels through an external analog multiplexer. It drives the mux select, runs the soc/eoc conversion handshake once per channel in round-robin order, and accumulates the four samples. It then presents their truncated average to a downstream consumer over the dav_/rfd handshake. It replaces four parallel converters with one, upstream of the averaging consumer.

## Interface
Parameters:
- TIMEOUT, 255: cycles to wait in a conversion state before aborting. Range 1..255, 8-bit counter. Used only with ADC_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock
- sel  out  2  analog mux select = channel under conversion
- soc  out  1  start of conversion to the ADC
- eoc  in  1  ADC end of conversion: 1 = idle/done, 0 = converting
- x  in  8  ADC result, valid while eoc = 1 after a conversion
- dav_  out  1  data available to consumer, active low
- rfd  in  1  consumer ready for data
- avg  out  8  average of last frame
- err  out  1  sticky conversion-timeout flag

## Operation
- All outputs are registered.
- Reset values: soc=0, dav_=1, sel=0, avg=0, err=0, sum=0, state=ARM.
- Reset has priority over every transition and aborts any frame or handshake in progress.
- The internal sum is 10 bits unsigned. This covers the worst case 4×255 = 1020, so no overflow is possible.
- States and transitions (evaluated each rising edge):
  - ARM: soc=0. If eoc=1, go to SOC and set soc<=1. Otherwise stay.
  - SOC: soc=1. If eoc=0, the ADC has started: set soc<=0 and go to CONV. Otherwise stay.
  - CONV: soc=0. If eoc=1, set sum<=sum+x. Then:
    - if sel=3, go to OUT;
    - otherwise set sel<=sel+1 and go to ARM.
  - OUT: avg<=sum[9:2] (truncating divide by 4). If rfd=1, set dav_<=0 and go to ACK. Otherwise stay with dav_=1.
  - ACK: dav_=0. If rfd=0, set dav_<=1, sel<=0, sum<=0 and go to ARM. Otherwise stay.
- sel changes only on the CONV→ARM transition and on the ACK exit. It is stable from ARM through CONV of a channel.
- avg changes only in OUT and is held stable through ACK and the whole next frame.
- x is sampled only on the CONV edge where eoc=1. It is ignored at all other times.

## Timing
- With eoc responding in the same cycle, the minimum is 3 cycles per channel (ARM, SOC, CONV).
- A frame is therefore at least 12 cycles, plus 2 for OUT/ACK.
- First dav_ fall occurs at the earliest 13 edges after reset deasserts.
- soc is high for at least one full cycle and falls on the edge after eoc=0 is sampled.
- dav_ falls no earlier than one edge after rfd=1 is sampled. It rises one edge after rfd=0 is sampled.
- If rfd is held high, dav_ stays low indefinitely and no new conversion starts. Conversions are not overlapped with the output handshake.
- Reset mid-handshake: dav_ returns to 1 on the reset edge, even if rfd is still high.

## Configuration
- ADC_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to SOC and to CONV, and increments each cycle spent there.
  - When it reaches TIMEOUT in SOC or CONV:
    - soc<=0 and err<=1;
    - the sample is taken as 0 (sum unchanged);
    - sequencing proceeds exactly as a normal CONV completion (sel advance, or OUT when sel=3).
  - err clears only on reset.
- ADC_TIMEOUT_EN undefined:
  - no counter;
  - SOC and CONV wait indefinitely;
  - err is tied to 0;
  - TIMEOUT is unused.

## Test plan
- Reset then ADC model returning x = 10, 20, 30, 40 for sel 0..3 → sel visits 0,1,2,3 in order; avg=25; dav_ falls after rfd=1.
- All four samples 255 → avg=255, no wrap. Samples 1,1,1,0 → avg=0 (truncation).
- Hold rfd=1 for 20 cycles after dav_ falls → dav_ stays 0, soc stays 0, sel stays 3. Drop rfd → dav_=1 next edge, sel=0, new frame starts.
- Assert reset during CONV of sel=2 and again while dav_=0 → next edge: soc=0, dav_=1, sel=0, avg unchanged from reset value 0, err=0.
- ADC_TIMEOUT_EN with TIMEOUT=8, eoc stuck at 1 for channel 1 → after 8 cycles in SOC: err=1, soc=0, sel advances. Samples 40,x,40,40 give avg=30.
- Without ADC_TIMEOUT_EN, same stuck eoc → FSM stays in SOC with soc=1 for 1000 cycles; err=0.

Source files
------------

// File: rtl/adc_mux_sequencer.sv
// adc_mux_sequencer: one 8-bit ADC shared by four analog channels.
// The block steps an external mux through channels 0..3 and runs the soc/eoc
// handshake once per channel. It adds the four samples and hands the
// truncated average to a consumer over the active-low dav_ / rfd handshake.
// Optional feature macro: ADC_TIMEOUT_EN. When it is defined, a stalled
// conversion is aborted after TIMEOUT cycles and the sticky err flag is set.
module adc_mux_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    output logic [1:0] sel,
    output logic       soc,
    input  logic       eoc,
    input  logic [7:0] x,
    output logic       dav_,
    input  logic       rfd,
    output logic [7:0] avg,
    output logic       err
);

    typedef enum logic [2:0] {
        ARM  = 3'd0,
        SOC  = 3'd1,
        CONV = 3'd2,
        OUT  = 3'd3,
        ACK  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        soc_q, soc_d;
    logic        dav_q, dav_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  avg_q, avg_d;
    logic        err_q, err_d;
    logic [9:0]  sum_q, sum_d;   // 4 x 255 = 1020 fits in 10 bits
    logic        timeout;        // current SOC/CONV wait has run out

`ifdef ADC_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;

    // Wait counter: cleared when SOC or CONV is entered, counts every cycle spent there
    always_comb begin
        cnt_inc = cnt_q + 8'd1;
        timeout = 1'b0;
        cnt_d   = cnt_q;
        if (state_q == SOC || state_q == CONV) begin
            cnt_d   = cnt_inc;
            timeout = (cnt_inc == TIMEOUT_CNT);
        end
        // Entering a wait state restarts the count from zero
        if ((state_q == ARM && eoc) || (state_q == SOC && !eoc)) begin
            cnt_d = 8'd0;
        end
    end

    // Wait counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without the abort feature SOC and CONV wait as long as the ADC needs
    always_comb begin
        timeout = 1'b0;
    end
`endif

    // Next-state and registered-output logic for the channel sequencer
    always_comb begin
        logic complete;
        state_d  = state_q;
        soc_d    = soc_q;
        dav_d    = dav_q;
        sel_d    = sel_q;
        avg_d    = avg_q;
        err_d    = err_q;
        sum_d    = sum_q;
        complete = 1'b0;

        case (state_q)
            ARM: begin
                // Only start once the ADC reports idle
                if (eoc) begin
                    soc_d   = 1'b1;
                    state_d = SOC;
                end
            end
            SOC: begin
                if (!eoc) begin
                    // ADC has acknowledged the start
                    soc_d   = 1'b0;
                    state_d = CONV;
                end else if (timeout) begin
                    soc_d    = 1'b0;
                    err_d    = 1'b1;
                    complete = 1'b1;
                end
            end
            CONV: begin
                if (eoc) begin
                    sum_d    = sum_q + {2'b00, x};
                    complete = 1'b1;
                end else if (timeout) begin
                    // Aborted sample counts as zero
                    soc_d    = 1'b0;
                    err_d    = 1'b1;
                    complete = 1'b1;
                end
            end
            OUT: begin
                avg_d = sum_q[9:2];
                if (rfd) begin
                    dav_d   = 1'b0;
                    state_d = ACK;
                end
            end
            ACK: begin
                // Hold data until the consumer drops rfd; then start a fresh frame
                if (!rfd) begin
                    dav_d   = 1'b1;
                    sel_d   = 2'd0;
                    sum_d   = 10'd0;
                    state_d = ARM;
                end
            end
            default: begin
                state_d = ARM;
            end
        endcase

        // Common end-of-channel sequencing, shared by normal and aborted conversions
        if (complete) begin
            if (sel_q == 2'd3) begin
                state_d = OUT;
            end else begin
                sel_d   = sel_q + 2'd1;
                state_d = ARM;
            end
        end
    end

    // State and output registers; reset aborts any frame or handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARM;
            soc_q   <= 1'b0;
            dav_q   <= 1'b1;
            sel_q   <= 2'd0;
            avg_q   <= 8'd0;
            err_q   <= 1'b0;
            sum_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            soc_q   <= soc_d;
            dav_q   <= dav_d;
            sel_q   <= sel_d;
            avg_q   <= avg_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
        end
    end

    assign sel  = sel_q;
    assign soc  = soc_q;
    assign dav_ = dav_q;
    assign avg  = avg_q;
    assign err  = err_q;

endmodule

// File: tb/tb_adc_mux_sequencer.sv
// Directed bench for adc_mux_sequencer with a behavioural ADC that answers
// soc in the same cycle. Expected values are hand-computed from the frame
// timing: 3 edges per channel, and dav_ falls on edge 13 when rfd is already high.
module tb_adc_mux_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       eoc   = 1'b1;
    logic [7:0] x     = 8'd0;
    logic       rfd   = 1'b0;
    logic [1:0] sel;
    logic       soc;
    logic       dav_;
    logic [7:0] avg;
    logic       err;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] samp [4];
    logic [2:0] stuck = 3'd4;   // channel whose ADC never starts; 4 = none

    adc_mux_sequencer #(.TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .sel   (sel),
        .soc   (soc),
        .eoc   (eoc),
        .x     (x),
        .dav_  (dav_),
        .rfd   (rfd),
        .avg   (avg),
        .err   (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance to the next falling edge, then update the ADC model
    task automatic tick();
        @(negedge clock);
        if (soc && ({1'b0, sel} != stuck)) begin
            eoc = 1'b0;
            x   = 8'hFF;          // garbage while converting
        end else begin
            eoc = 1'b1;
            x   = samp[sel];
        end
    endtask

    // Run one frame with rfd held high and wait for dav_ to fall
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic [7:0] exp_avg,
                             input logic [7:0] prev_avg, input string name);
        int         n;
        int         nsoc;
        logic       prev_soc;
        logic [1:0] seen [4];
        samp[0] = a; samp[1] = b; samp[2] = c; samp[3] = d;
        rfd = 1'b1;
        n = 0;
        nsoc = 0;
        prev_soc = soc;
        for (int i = 0; i < 4; i++) seen[i] = 2'd0;
        while (dav_ && n < 200) begin
            tick();
            n++;
            if (soc && !prev_soc && nsoc < 4) begin
                seen[nsoc] = sel;
                nsoc++;
            end
            prev_soc = soc;
            if (n == 12) check({name, "_avg_held"}, avg, prev_avg);
        end
        check({name, "_dav_edge"}, n, 13);
        check({name, "_avg"}, avg, exp_avg);
        check({name, "_sel_out"}, sel, 3);
        check({name, "_nsoc"}, nsoc, 4);
        for (int i = 0; i < 4; i++) check({name, "_sel_order"}, seen[i], i);
        $display("frame %s: samples %0d %0d %0d %0d avg=%0d after %0d edges", name, a, b, c, d, avg, n);
    endtask

    // Drop rfd and confirm the handshake closes one edge later
    task automatic release_frame(input string name);
        rfd = 1'b0;
        tick();
        check({name, "_dav_rise"}, dav_, 1);
        check({name, "_sel_wrap"}, sel, 0);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_soc"}, soc, 0);
        check({name, "_dav"}, dav_, 1);
        check({name, "_sel"}, sel, 0);
        check({name, "_avg"}, avg, 0);
        check({name, "_err"}, err, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) samp[i] = 8'd0;

        // Power-on reset
        reset = 1'b1;
        repeat (3) tick();
        check_reset_state("por");
        reset = 1'b0;

        // Basic frame, then rfd held high for 20 cycles
        run_frame(8'd10, 8'd20, 8'd30, 8'd40, 8'd25, 8'd0, "f1");
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_dav", dav_, 0);
            check("hold_soc", soc, 0);
            check("hold_sel", sel, 3);
        end
        $display("hold: rfd high 20 cycles, dav_=%0d soc=%0d sel=%0d", dav_, soc, sel);
        release_frame("f1");

        // Truncation and full-scale frames
        run_frame(8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd25, "f2");
        release_frame("f2");
        run_frame(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, "f3");
        release_frame("f3");

        // Reset while channel 2 is in CONV
        samp[0] = 8'd10; samp[1] = 8'd20; samp[2] = 8'd30; samp[3] = 8'd40;
        rfd = 1'b1;
        repeat (8) tick();
        check("conv2_sel", sel, 2);
        check("conv2_soc", soc, 0);
        reset = 1'b1;
        tick();
        check_reset_state("rst_conv");
        $display("reset during CONV of channel 2: sel=%0d avg=%0d", sel, avg);
        reset = 1'b0;

        // Reset while dav_ is low and rfd still high
        run_frame(8'd10, 8'd20, 8'd30, 8'd40, 8'd25, 8'd0, "f4");
        reset = 1'b1;
        tick();
        check_reset_state("rst_ack");
        $display("reset during ACK: dav_=%0d avg=%0d", dav_, avg);

        // Channel 1 ADC never starts conversion
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stuck = 3'd1;
        samp[0] = 8'd40; samp[1] = 8'd200; samp[2] = 8'd40; samp[3] = 8'd40;
`ifdef ADC_TIMEOUT_EN
        begin
            int n;
            rfd = 1'b1;
            n = 0;
            while (dav_ && n < 200) begin
                tick();
                n++;
                if (n == 11) begin
                    check("to_wait_soc", soc, 1);
                    check("to_wait_err", err, 0);
                    check("to_wait_sel", sel, 1);
                end
                if (n == 12) begin
                    check("to_fire_soc", soc, 0);
                    check("to_fire_err", err, 1);
                    check("to_fire_sel", sel, 2);
                end
            end
            check("to_dav_edge", n, 19);
            check("to_avg", avg, 30);
            check("to_err_sticky", err, 1);
            $display("timeout frame: avg=%0d err=%0d after %0d edges", avg, err, n);
        end
`else
        rfd = 1'b0;
        repeat (1000) tick();
        check("stuck_soc", soc, 1);
        check("stuck_sel", sel, 1);
        check("stuck_err", err, 0);
        check("stuck_dav", dav_, 1);
        $display("stuck channel 1: soc=%0d sel=%0d err=%0d after 1000 cycles", soc, sel, err);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
